display_arbiter: RTL and testbench

Shares the 8-digit seven-segment display between two sources: the keypad entry path (shift register NUMB/MASK) and a message source such as a result or status word. It sits between those sources and `segment_controller` in the 100 MHz domain. Message requests are accepted with a req/ack handshake and shown for a fixed hold time. Entry activity always pre-empts a message, and a guard window afterwards keeps the entry view on screen.

---
 rtl/display_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_display_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares the 8-digit seven-segment display between the keypad entry path
//   and a message source (result/status word). A message is accepted with a
//   req/ack handshake and held on screen for HOLD_CYCLES. Any entry activity
//   pre-empts the message immediately. After a message ends, a guard window
//   of GUARD_CYCLES keeps the entry view on screen. Each entry_activity pulse
//   restarts that window.
//
// Parameters
//   HOLD_CYCLES   cycles a message stays visible (>=1)
//   GUARD_CYCLES  minimum entry-view cycles after a message ends (>=1)
//   BLINK_CYCLES  half-period of the newest-digit blink (>=1, blink build only)
//
// Ports
//   clk             system clock (100 MHz)
//   rst_n           synchronous active-low reset
//   entry_numb/mask entry value (nibble i = digit i) and digit enables
//   entry_activity  one-cycle pulse on an enter/reset keypad event
//   msg_req         message request, held until msg_ack
//   msg_numb/mask   message value and digit enables, sampled at accept
//   msg_ack         one-cycle pulse: message accepted
//   msg_done        one-cycle pulse: message display ended
//   msg_aborted     qualifies msg_done: 1 = ended by entry pre-emption
//   numb/mask       registered value and enables to segment_controller
//   owner           0 = entry view, 1 = message view
//
// Configuration
//   ENTRY_BLINK_EN  when defined, mask[0] blinks in the entry view with a
//                   half-period of BLINK_CYCLES. The blink counter and phase
//                   restart on entry_activity.

module display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned GUARD_CYCLES = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] entry_numb,
  input  logic [7:0]  entry_mask,
  input  logic        entry_activity,
  input  logic        msg_req,
  input  logic [31:0] msg_numb,
  input  logic [7:0]  msg_mask,
  output logic        msg_ack,
  output logic        msg_done,
  output logic        msg_aborted,
  output logic [31:0] numb,
  output logic [7:0]  mask,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_SHOW  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GUARD_LOAD = 32'(GUARD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] numb_d;
  logic [7:0]  mask_d;
  logic        owner_d, ack_d, done_d, aborted_d;

`ifdef ENTRY_BLINK_EN
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);

  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;

  // Free-running half-period counter. Entry activity restarts it with the
  // digit lit, so a freshly typed digit is visible straight away.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    phase_d     = phase_q;
    if (entry_activity) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`endif

  // State and counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. In SHOW, entry activity outranks hold expiry. In GUARD,
  // activity outranks guard expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ENTRY: begin
        if (msg_req && !entry_activity) begin
          state_d = ST_SHOW;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_SHOW: begin
        if (entry_activity || (cnt_q == '0)) begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_LOAD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_GUARD: begin
        if (entry_activity) begin
          cnt_d = GUARD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_ENTRY;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. These values are registered below, so they follow the
  // state being entered rather than the current one. While a message is
  // showing, numb/mask simply hold their registered value. That register
  // doubles as the message latch.
  always_comb begin
    ack_d     = (state_q == ST_ENTRY) && (state_d == ST_SHOW);
    done_d    = (state_q == ST_SHOW)  && (state_d == ST_GUARD);
    aborted_d = done_d && entry_activity;
    numb_d    = entry_numb;
    mask_d    = entry_mask;
    owner_d   = 1'b0;
`ifdef ENTRY_BLINK_EN
    mask_d[0] = entry_mask[0] & phase_d;
`endif
    if (ack_d) begin
      numb_d  = msg_numb;
      mask_d  = msg_mask;
      owner_d = 1'b1;
    end else if (state_d == ST_SHOW) begin
      numb_d  = numb;
      mask_d  = mask;
      owner_d = 1'b1;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      numb        <= '0;
      mask        <= '0;
      owner       <= 1'b0;
      msg_ack     <= 1'b0;
      msg_done    <= 1'b0;
      msg_aborted <= 1'b0;
    end else begin
      numb        <= numb_d;
      mask        <= mask_d;
      owner       <= owner_d;
      msg_ack     <= ack_d;
      msg_done    <= done_d;
      msg_aborted <= aborted_d;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
//   Directed bench for display_arbiter with HOLD=4, GUARD=3, BLINK=2.
//   Covers reset, a normal message, a request that coincides with activity,
//   pre-emption with a guard extension, reset mid-message, and the entry
//   mask (blinking when ENTRY_BLINK_EN is defined, constant otherwise).

module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] entry_numb;
  logic [7:0]  entry_mask;
  logic        entry_activity;
  logic        msg_req;
  logic [31:0] msg_numb;
  logic [7:0]  msg_mask;
  logic        msg_ack, msg_done, msg_aborted, owner;
  logic [31:0] numb;
  logic [7:0]  mask;

  int checks = 0;
  int errors = 0;

  logic [7:0] blink_exp [5];

  display_arbiter #(
    .HOLD_CYCLES (4),
    .GUARD_CYCLES(3),
    .BLINK_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_numb    (entry_numb),
    .entry_mask    (entry_mask),
    .entry_activity(entry_activity),
    .msg_req       (msg_req),
    .msg_numb      (msg_numb),
    .msg_mask      (msg_mask),
    .msg_ack       (msg_ack),
    .msg_done      (msg_done),
    .msg_aborted   (msg_aborted),
    .numb          (numb),
    .mask          (mask),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkView(input string tag, input logic [31:0] exp_numb,
                           input logic [7:0] exp_mask, input logic exp_owner);
    checkOutput({tag, "_numb"}, numb, exp_numb);
    checkOutput({tag, "_mask"}, 32'(mask), 32'(exp_mask));
    checkOutput({tag, "_owner"}, 32'(owner), 32'(exp_owner));
  endtask

  task automatic checkPulses(input string tag, input logic exp_ack,
                             input logic exp_done, input logic exp_aborted);
    checkOutput({tag, "_ack"}, 32'(msg_ack), 32'(exp_ack));
    checkOutput({tag, "_done"}, 32'(msg_done), 32'(exp_done));
    checkOutput({tag, "_aborted"}, 32'(msg_aborted), 32'(exp_aborted));
  endtask

  task automatic applyStimulus(input logic rst_v, input logic act,
                               input logic req, input logic [31:0] mnumb,
                               input logic [7:0] mmask);
    rst_n          = rst_v;
    entry_activity = act;
    msg_req        = req;
    msg_numb       = mnumb;
    msg_mask       = mmask;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ENTRY_BLINK_EN
    blink_exp = '{8'h0F, 8'h0F, 8'h0E, 8'h0E, 8'h0F};
`else
    blink_exp = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
`endif
    entry_numb = 32'h0000_1234;
    entry_mask = 8'h0F;

    // Reset held for two cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    step();
    step();
    checkView("reset", 32'h0, 8'h00, 1'b0);
    checkPulses("reset", 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    step();
    checkView("entry", 32'h0000_1234, 8'h0F, 1'b0);

    // Normal message. msg_req stays high throughout.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'hFF);
    step();
    checkView("accept", 32'hDEAD_BEEF, 8'hFF, 1'b1);
    checkPulses("accept", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678, 8'hF0);
    for (int i = 1; i < 4; i++) begin
      step();
      checkView($sformatf("show%0d", i), 32'hDEAD_BEEF, 8'hFF, 1'b1);
      checkPulses($sformatf("show%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step();
    checkOutput("hold_end_owner", 32'(owner), 32'd0);
    checkOutput("hold_end_numb", numb, 32'h0000_1234);
    checkPulses("hold_end", 1'b0, 1'b1, 1'b0);
    // Three guard cycles, then one ENTRY cycle, without an ack.
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("guard%0d_owner", i), 32'(owner), 32'd0);
      checkPulses($sformatf("guard%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step();
    checkOutput("reaccept_ack", 32'(msg_ack), 32'd1);
    checkView("reaccept", 32'h1234_5678, 8'hF0, 1'b1);

    // Pre-emption in the 2nd SHOW cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    step();
    checkOutput("show2_owner", 32'(owner), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8'h00);
    step();
    checkOutput("preempt_owner", 32'(owner), 32'd0);
    checkOutput("preempt_numb", numb, 32'h0000_1234);
    checkPulses("preempt", 1'b0, 1'b1, 1'b1);
    // A request raised during GUARD is ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hAAAA_5555, 8'h3C);
    step();
    checkPulses("guard_a", 1'b0, 1'b0, 1'b0);
    // Activity in GUARD restarts the three-cycle window.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hAAAA_5555, 8'h3C);
    step();
    checkPulses("guard_ext0", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hAAAA_5555, 8'h3C);
    for (int i = 1; i < 4; i++) begin
      step();
      checkOutput($sformatf("guard_ext%0d_ack", i), 32'(msg_ack), 32'd0);
      checkOutput($sformatf("guard_ext%0d_owner", i), 32'(owner), 32'd0);
    end

    // Request and activity in the same ENTRY cycle: entry wins.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hAAAA_5555, 8'h3C);
    step();
    checkOutput("simul_ack", 32'(msg_ack), 32'd0);
    checkOutput("simul_owner", 32'(owner), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hAAAA_5555, 8'h3C);
    step();
    checkPulses("late_accept", 1'b1, 1'b0, 1'b0);
    checkView("late_accept", 32'hAAAA_5555, 8'h3C, 1'b1);

    // Reset mid-SHOW: outputs cleared, no msg_done afterwards.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    step();
    checkOutput("midshow_owner", 32'(owner), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    step();
    checkView("midrst", 32'h0, 8'h00, 1'b0);
    checkPulses("midrst", 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    step();
    checkOutput("postrst_numb", numb, 32'h0000_1234);
    checkOutput("postrst_owner", 32'(owner), 32'd0);
    checkPulses("postrst", 1'b0, 1'b0, 1'b0);
    step();
    checkPulses("postrst2", 1'b0, 1'b0, 1'b0);

    // Entry mask after an activity pulse.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8'h00);
    step();
    checkOutput("blink0_mask", 32'(mask), 32'(blink_exp[0]));
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    for (int i = 1; i < 5; i++) begin
      step();
      checkOutput($sformatf("blink%0d_mask", i), 32'(mask), 32'(blink_exp[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
